// File: rtl/dmem_dma.sv
// Block-copy DMA engine acting as a second initiator on the data-memory bus.
// Optional constant-fill mode is enabled by defining DMEM_DMA_FILL_EN.
module dmem_dma #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
`ifdef DMEM_DMA_FILL_EN
    input  logic             fill,
`endif
    output logic             busy,
    output logic             done,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    output logic             mem_we,
    input  logic [31:0]      mem_rd
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [31:0]      cur_src_r, cur_src_s;
    logic [31:0]      cur_dst_r, cur_dst_s;
    logic [LEN_W-1:0] remaining_r, remaining_s;
    logic [31:0]      data_buf_r, data_buf_s;
    logic             fill_mode_s;

    logic             busy_s;
    logic             done_s;
    logic             bus_req_s;
    logic [31:0]      mem_a_s;
    logic [31:0]      mem_wd_s;
    logic             mem_we_s;

`ifdef DMEM_DMA_FILL_EN
    logic             fill_r, fill_s;

    // Fill-mode flag, latched together with the transfer parameters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fill_r <= 1'b0;
        end else begin
            fill_r <= fill_s;
        end
    end

    assign fill_mode_s = fill_r;
`else
    assign fill_mode_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transfer datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_src_r   <= 32'd0;
            cur_dst_r   <= 32'd0;
            remaining_r <= LEN_ZERO;
            data_buf_r  <= 32'd0;
        end else begin
            cur_src_r   <= cur_src_s;
            cur_dst_r   <= cur_dst_s;
            remaining_r <= remaining_s;
            data_buf_r  <= data_buf_s;
        end
    end

    // Next-state, datapath updates and bus drive.
    always_comb begin
        state_s     = state_r;
        cur_src_s   = cur_src_r;
        cur_dst_s   = cur_dst_r;
        remaining_s = remaining_r;
        data_buf_s  = data_buf_r;
`ifdef DMEM_DMA_FILL_EN
        fill_s      = fill_r;
`endif
        busy_s      = 1'b0;
        done_s      = 1'b0;
        bus_req_s   = 1'b0;
        mem_a_s     = 32'd0;
        mem_wd_s    = 32'd0;
        mem_we_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    cur_src_s   = src & 32'hFFFF_FFFC;
                    cur_dst_s   = dst & 32'hFFFF_FFFC;
                    remaining_s = len;
`ifdef DMEM_DMA_FILL_EN
                    fill_s      = fill;
`endif
                    if (len == LEN_ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_REQ: begin
                busy_s    = 1'b1;
                bus_req_s = 1'b1;
                if (bus_gnt) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_REQ;
                end
            end

            ST_READ: begin
                busy_s    = 1'b1;
                bus_req_s = 1'b1;
                mem_a_s   = cur_src_r;
                if (bus_gnt) begin
                    data_buf_s = mem_rd;
                    cur_src_s  = cur_src_r + 32'd4;
                    state_s    = ST_WRITE;
                end else begin
                    // Lost the bus mid-read: re-arbitrate before trying again.
                    state_s = ST_REQ;
                end
            end

            ST_WRITE: begin
                busy_s    = 1'b1;
                bus_req_s = 1'b1;
                mem_a_s   = cur_dst_r;
                mem_wd_s  = data_buf_r;
                mem_we_s  = bus_gnt;
                if (bus_gnt) begin
                    cur_dst_s   = cur_dst_r + 32'd4;
                    remaining_s = remaining_r - LEN_ONE;
                    if (remaining_r == LEN_ONE) begin
                        state_s = ST_DONE;
                    end else if (fill_mode_s) begin
                        state_s = ST_WRITE;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_WRITE;
                end
            end

            ST_DONE: begin
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from the state flop; mem_we must follow the
    // grant within the same cycle so the mux never sees an ungranted write.
    assign busy    = busy_s;
    assign done    = done_s;
    assign bus_req = bus_req_s;
    assign mem_a   = mem_a_s;
    assign mem_wd  = mem_wd_s;
    assign mem_we  = mem_we_s;

endmodule
